// File: rtl/gsm_ingress_alloc_pkg.sv
// Shared definitions for the GSM per-port ingress allocator: FSM state codes
// and parameter defaults.
package gsm_ingress_alloc_pkg;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam int unsigned DEF_PF_DEPTH   = 2;
    localparam int unsigned DEF_DCNT_WIDTH = 16;

endpackage

// File: rtl/gsm_ingress_alloc_if.sv
// Cell handshake, HMP pointer pop and GSM write-port signals of one switch port.
interface gsm_ingress_alloc_if #(
    parameter int unsigned MWIDTH = 4,
    parameter int unsigned AWIDTH = 7
);
    logic              i_cell_valid;
    logic [MWIDTH-1:0] i_cell_mcast;
    logic              o_cell_ready;
    logic              i_hmp_valid;
    logic [AWIDTH-1:0] i_hmp_addr;
    logic              o_hmp_rd;
    logic              o_wr_en;
    logic [AWIDTH-1:0] o_wr_addr;
    logic [MWIDTH-1:0] o_multicast;

    modport slave (
        input  i_cell_valid, i_cell_mcast, i_hmp_valid, i_hmp_addr,
        output o_cell_ready, o_hmp_rd, o_wr_en, o_wr_addr, o_multicast
    );

    modport master (
        output i_cell_valid, i_cell_mcast, i_hmp_valid, i_hmp_addr,
        input  o_cell_ready, o_hmp_rd, o_wr_en, o_wr_addr, o_multicast
    );
endinterface

// File: rtl/gsm_ingress_alloc_ptr_prefetch.sv
// Small synchronous FIFO holding prefetched free-buffer pointers; no bypass,
// so a pointer pushed this cycle is visible at dout from the next cycle.
module gsm_ptr_prefetch #(
    parameter int unsigned AWIDTH = 7,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [AWIDTH-1:0] din,
    output logic [AWIDTH-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_next(rd_ptr_q);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assign dout  = mem_q[rd_ptr_q];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
endmodule

// File: rtl/gsm_ingress_alloc.sv
// Per-port ingress cell allocator: prefetches HMP pointers, issues GSM writes
// for accepted cells, tracks buffers in use and zero-multicast drops.
module gsm_ingress_alloc
    import gsm_ingress_alloc_pkg::*;
#(
    parameter int unsigned MWIDTH     = 4,
    parameter int unsigned AWIDTH     = 7,
    parameter int unsigned PF_DEPTH   = DEF_PF_DEPTH,
    parameter int unsigned DCNT_WIDTH = DEF_DCNT_WIDTH
) (
    input  logic                  clk_80M,
    input  logic                  clr_80M,
    input  logic                  i_pause,
    input  logic                  i_bf_free_flag,
    gsm_ingress_alloc_if.slave    bus,
    output logic [AWIDTH:0]       o_used_cnt,
    output logic [DCNT_WIDTH-1:0] o_drop_cnt,
    output logic                  o_err_underflow
);
    localparam int unsigned CW = $clog2(PF_DEPTH + 1);

    logic [1:0]            state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [AWIDTH-1:0]     wr_addr_q, wr_addr_d;
    logic [MWIDTH-1:0]     mcast_q, mcast_d;
    logic [AWIDTH:0]       used_q, used_d;
    logic [DCNT_WIDTH-1:0] drop_q, drop_d;
    logic                  err_q, err_d;

    logic              pf_pop, pf_push, pf_empty, pf_full;
    logic [AWIDTH-1:0] pf_head;
    logic [CW-1:0]     pf_count;
    logic              mcast_zero, ready, accept, alloc, drop;

    assign mcast_zero = (bus.i_cell_mcast == '0);
    // Zero-multicast cells need no pointer, so they are taken even with an empty prefetch.
    assign ready      = (state_q == ST_RUN) && (!pf_empty || mcast_zero);
    assign accept     = bus.i_cell_valid && ready;
    assign alloc      = accept && !mcast_zero;
    assign drop       = accept && mcast_zero;
    assign pf_pop     = alloc;
    assign pf_push    = bus.i_hmp_valid && (!pf_full || pf_pop);

    gsm_ptr_prefetch #(
        .AWIDTH (AWIDTH),
        .DEPTH  (PF_DEPTH),
        .CW     (CW)
    ) u_prefetch (
        .clk   (clk_80M),
        .rst   (clr_80M),
        .push  (pf_push),
        .pop   (pf_pop),
        .din   (bus.i_hmp_addr),
        .dout  (pf_head),
        .count (pf_count),
        .empty (pf_empty),
        .full  (pf_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (i_pause) state_d = ST_PAUSE;
                      else if (pf_count != '0) state_d = ST_RUN;
            ST_RUN:   if (i_pause) state_d = ST_PAUSE;
            ST_PAUSE: if (!i_pause) state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
    end

    always_comb begin
        wr_en_d   = alloc;
        wr_addr_d = alloc ? pf_head : wr_addr_q;
        mcast_d   = alloc ? bus.i_cell_mcast : mcast_q;

        used_d = used_q;
        err_d  = err_q;
        if (alloc && !i_bf_free_flag) begin
            used_d = used_q + 1'b1;
        end else if (i_bf_free_flag && !alloc) begin
            if (used_q == '0) err_d = 1'b1;
            else              used_d = used_q - 1'b1;
        end

        drop_d = drop_q;
        if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk_80M) begin
        if (clr_80M) begin
            state_q   <= ST_INIT;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            mcast_q   <= '0;
            used_q    <= '0;
            drop_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            mcast_q   <= mcast_d;
            used_q    <= used_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_cell_ready = ready;
    assign bus.o_hmp_rd     = pf_push;
    assign bus.o_wr_en      = wr_en_q;
    assign bus.o_wr_addr    = wr_addr_q;
    assign bus.o_multicast  = mcast_q;
    assign o_used_cnt       = used_q;
    assign o_drop_cnt       = drop_q;
    assign o_err_underflow  = err_q;
endmodule

// File: tb/tb_gsm_ingress_alloc.sv
// Directed vector bench for gsm_ingress_alloc: cycle table plus reset and
// drop-counter saturation sequences.
module tb_gsm_ingress_alloc;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [3:0] mc;
        logic       pause;
        logic       hv;
        logic [6:0] ha;
        logic       free;
        logic       x_rd;
        logic       x_rdy;
        logic       x_we;
        logic [6:0] x_addr;
        logic [3:0] x_mc;
        logic [7:0] x_used;
        logic [15:0] x_drop;
        logic       x_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        pause;
    logic        free;
    logic [7:0]  used;
    logic [15:0] drop;
    logic        err;

    int tests = 0;
    int fails = 0;

    vec_t vq[$];

    always #5 clk = ~clk;

    gsm_ingress_alloc_if #(.MWIDTH(4), .AWIDTH(7)) bus ();

    gsm_ingress_alloc #(
        .MWIDTH     (4),
        .AWIDTH     (7),
        .PF_DEPTH   (2),
        .DCNT_WIDTH (16)
    ) dut (
        .clk_80M         (clk),
        .clr_80M         (clr),
        .i_pause         (pause),
        .i_bf_free_flag  (free),
        .bus             (bus),
        .o_used_cnt      (used),
        .o_drop_cnt      (drop),
        .o_err_underflow (err)
    );

    function automatic void chk(input int idx, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL step%0d %s: got %0h expected %0h", idx, name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic rst, input logic valid, input logic [3:0] mc,
                                input logic p, input logic hv, input logic [6:0] ha,
                                input logic fr, input logic x_rd, input logic x_rdy,
                                input logic x_we, input logic [6:0] x_addr,
                                input logic [3:0] x_mc, input logic [7:0] x_used,
                                input logic [15:0] x_drop, input logic x_err);
        vec_t v;
        v.rst = rst; v.valid = valid; v.mc = mc; v.pause = p; v.hv = hv; v.ha = ha;
        v.free = fr; v.x_rd = x_rd; v.x_rdy = x_rdy; v.x_we = x_we; v.x_addr = x_addr;
        v.x_mc = x_mc; v.x_used = x_used; v.x_drop = x_drop; v.x_err = x_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        clr              = v.rst;
        bus.i_cell_valid = v.valid;
        bus.i_cell_mcast = v.mc;
        pause            = v.pause;
        bus.i_hmp_valid  = v.hv;
        bus.i_hmp_addr   = v.ha;
        free             = v.free;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk(idx, "hmp_rd", 32'(bus.o_hmp_rd), 32'(v.x_rd));
        chk(idx, "cell_ready", 32'(bus.o_cell_ready), 32'(v.x_rdy));
        @(posedge clk);
        #1;
        chk(idx, "wr_en", 32'(bus.o_wr_en), 32'(v.x_we));
        chk(idx, "wr_addr", 32'(bus.o_wr_addr), 32'(v.x_addr));
        chk(idx, "multicast", 32'(bus.o_multicast), 32'(v.x_mc));
        chk(idx, "used_cnt", 32'(used), 32'(v.x_used));
        chk(idx, "drop_cnt", 32'(drop), 32'(v.x_drop));
        chk(idx, "err_underflow", 32'(err), 32'(v.x_err));
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 4'h0, 0, 0, 7'd0, 0, 0, 0, 0, 7'd0, 4'h0, 8'd0, 16'd0, 0);
        drive(idle);
        clr = 1'b1;

        //          rst v  mc     p  hv ha      fr  rd rdy we addr    mc     used   drop    err
        // prefetch fill and INIT -> RUN
        vq.push_back(mk(0, 0, 4'h0, 0, 1, 7'd5,  0,  1, 0,  0, 7'd0,  4'h0, 8'd0, 16'd0, 0));
        vq.push_back(mk(0, 0, 4'h0, 0, 1, 7'd6,  0,  1, 0,  0, 7'd0,  4'h0, 8'd0, 16'd0, 0));
        vq.push_back(mk(0, 0, 4'h0, 0, 1, 7'd7,  0,  0, 1,  0, 7'd0,  4'h0, 8'd0, 16'd0, 0));
        // allocations, stall on empty prefetch, refill with addr 9
        vq.push_back(mk(0, 1, 4'hA, 0, 0, 7'd0,  0,  0, 1,  1, 7'd5,  4'hA, 8'd1, 16'd0, 0));
        vq.push_back(mk(0, 1, 4'h3, 0, 0, 7'd0,  0,  0, 1,  1, 7'd6,  4'h3, 8'd2, 16'd0, 0));
        vq.push_back(mk(0, 1, 4'h4, 0, 0, 7'd0,  0,  0, 0,  0, 7'd6,  4'h3, 8'd2, 16'd0, 0));
        vq.push_back(mk(0, 1, 4'h4, 0, 1, 7'd9,  0,  1, 0,  0, 7'd6,  4'h3, 8'd2, 16'd0, 0));
        vq.push_back(mk(0, 1, 4'h4, 0, 0, 7'd0,  0,  0, 1,  1, 7'd9,  4'h4, 8'd3, 16'd0, 0));
        // zero-multicast drop with empty prefetch
        vq.push_back(mk(0, 1, 4'h0, 0, 0, 7'd0,  0,  0, 1,  0, 7'd9,  4'h4, 8'd3, 16'd1, 0));
        vq.push_back(mk(0, 0, 4'h0, 0, 1, 7'd10, 0,  1, 1,  0, 7'd9,  4'h4, 8'd3, 16'd1, 0));
        // free coincident with allocate at used=3, then drain and underflow
        vq.push_back(mk(0, 1, 4'h1, 0, 0, 7'd0,  1,  0, 1,  1, 7'd10, 4'h1, 8'd3, 16'd1, 0));
        vq.push_back(mk(0, 0, 4'h0, 0, 0, 7'd0,  1,  0, 1,  0, 7'd10, 4'h1, 8'd2, 16'd1, 0));
        vq.push_back(mk(0, 0, 4'h0, 0, 0, 7'd0,  1,  0, 1,  0, 7'd10, 4'h1, 8'd1, 16'd1, 0));
        vq.push_back(mk(0, 0, 4'h0, 0, 0, 7'd0,  1,  0, 1,  0, 7'd10, 4'h1, 8'd0, 16'd1, 0));
        vq.push_back(mk(0, 0, 4'h0, 0, 0, 7'd0,  1,  0, 1,  0, 7'd10, 4'h1, 8'd0, 16'd1, 1));
        vq.push_back(mk(0, 0, 4'h0, 0, 0, 7'd0,  0,  0, 1,  0, 7'd10, 4'h1, 8'd0, 16'd1, 1));
        // pause mid-stream: accept in the rising cycle, refill while paused, resume
        vq.push_back(mk(0, 0, 4'h0, 0, 1, 7'd20, 0,  1, 1,  0, 7'd10, 4'h1, 8'd0, 16'd1, 1));
        vq.push_back(mk(0, 0, 4'h0, 0, 1, 7'd21, 0,  1, 1,  0, 7'd10, 4'h1, 8'd0, 16'd1, 1));
        vq.push_back(mk(0, 1, 4'h1, 1, 0, 7'd0,  0,  0, 1,  1, 7'd20, 4'h1, 8'd1, 16'd1, 1));
        vq.push_back(mk(0, 1, 4'h2, 1, 1, 7'd22, 0,  1, 0,  0, 7'd20, 4'h1, 8'd1, 16'd1, 1));
        vq.push_back(mk(0, 1, 4'h2, 1, 1, 7'd23, 0,  0, 0,  0, 7'd20, 4'h1, 8'd1, 16'd1, 1));
        vq.push_back(mk(0, 1, 4'h2, 0, 0, 7'd0,  0,  0, 0,  0, 7'd20, 4'h1, 8'd1, 16'd1, 1));
        vq.push_back(mk(0, 1, 4'h2, 0, 0, 7'd0,  0,  0, 1,  1, 7'd21, 4'h2, 8'd2, 16'd1, 1));
        vq.push_back(mk(0, 1, 4'h4, 0, 1, 7'd24, 0,  1, 1,  1, 7'd22, 4'h4, 8'd3, 16'd1, 1));
        // reset mid-burst; prefetch discarded so FSM stays in INIT
        vq.push_back(mk(1, 1, 4'h8, 0, 0, 7'd0,  0,  0, 1,  0, 7'd0,  4'h0, 8'd0, 16'd0, 0));
        vq.push_back(mk(0, 1, 4'h8, 0, 0, 7'd0,  0,  0, 0,  0, 7'd0,  4'h0, 8'd0, 16'd0, 0));
        vq.push_back(mk(0, 0, 4'h0, 0, 0, 7'd0,  0,  0, 0,  0, 7'd0,  4'h0, 8'd0, 16'd0, 0));
        // one pointer to reach RUN for the drop-saturation run
        vq.push_back(mk(0, 0, 4'h0, 0, 1, 7'd30, 0,  1, 0,  0, 7'd0,  4'h0, 8'd0, 16'd0, 0));
        vq.push_back(mk(0, 0, 4'h0, 0, 0, 7'd0,  0,  0, 0,  0, 7'd0,  4'h0, 8'd0, 16'd0, 0));

        // power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk(-1, "rst_wr_en", 32'(bus.o_wr_en), 32'd0);
        chk(-1, "rst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
        chk(-1, "rst_multicast", 32'(bus.o_multicast), 32'd0);
        chk(-1, "rst_used_cnt", 32'(used), 32'd0);
        chk(-1, "rst_drop_cnt", 32'(drop), 32'd0);
        chk(-1, "rst_err", 32'(err), 32'd0);
        chk(-1, "rst_ready", 32'(bus.o_cell_ready), 32'd0);

        foreach (vq[i]) apply(i, vq[i]);

        // drop counter saturation: 70000 zero-multicast cells back to back
        @(negedge clk);
        drive(idle);
        bus.i_cell_valid = 1'b1;
        for (int unsigned n = 1; n <= 70000; n++) begin
            @(posedge clk);
            #1;
            if (n == 1)     chk(1001, "drop_first", 32'(drop), 32'd1);
            if (n == 65534) chk(1002, "drop_fffe", 32'(drop), 32'hFFFE);
            if (n == 65535) chk(1003, "drop_ffff", 32'(drop), 32'hFFFF);
            if (n == 65536) chk(1004, "drop_sat", 32'(drop), 32'hFFFF);
        end
        chk(1005, "drop_end", 32'(drop), 32'hFFFF);
        chk(1006, "drop_wr_en", 32'(bus.o_wr_en), 32'd0);
        chk(1007, "drop_used", 32'(used), 32'd0);
        chk(1008, "drop_ready", 32'(bus.o_cell_ready), 32'd1);

        @(negedge clk);
        drive(idle);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk(1009, "clr_drop", 32'(drop), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gsm_ingress_alloc.md
Name: gsm_ingress_alloc

Overview:
- Per-port ingress cell allocator for the grouped-shared-memory switch, running in the 80 MHz port domain. One instance per switch port.
- Pops free buffer pointers from its Hardware Malloc Pipe (HMP) port of the GSM unit and keeps a small prefetch buffer of them.
- For each accepted cell, issues the write enable, write address and multicast vector to the GSM unit's ingress malloc port for that port.
- Counts buffers in use via the buffer-free flag, and counts cells dropped for an empty multicast vector.

Parameters:
- MWIDTH, 4, number of output ports (width of the multicast vector).
- AWIDTH, 7, per-port buffer pointer width.
- PF_DEPTH, 2, depth of the pointer prefetch buffer (1..4).
- DCNT_WIDTH, 16, width of the drop counter.

Ports:
- clk_80M  in  1  port-domain clock.
- clr_80M  in  1  synchronous active-high reset.
- i_cell_valid  in  1  a cell header is presented.
- i_cell_mcast  in  MWIDTH  destination port vector of the presented cell.
- o_cell_ready  out  1  cell accepted when valid&ready.
- i_pause  in  1  stop accepting cells; prefetch continues.
- i_hmp_valid  in  1  HMP has a pointer (from o_hmp_valid[k]).
- i_hmp_addr  in  AWIDTH  head pointer, show-ahead (from o_hmp_addr slice k).
- o_hmp_rd  out  1  pop the HMP (to i_hmp_rd[k]).
- i_bf_free_flag  in  1  one-cycle pulse: one buffer of this port was freed.
- o_wr_en  out  1  to i_wr_en[k].
- o_wr_addr  out  AWIDTH  to i_wr_addr slice k.
- o_multicast  out  MWIDTH  to i_multicast slice k.
- o_used_cnt  out  AWIDTH+1  buffers currently allocated by this port.
- o_drop_cnt  out  DCNT_WIDTH  saturating count of zero-multicast drops.
- o_err_underflow  out  1  sticky: a free pulse arrived with o_used_cnt==0.

Behaviour:
- Single clock clk_80M. Reset clr_80M is synchronous and active-high.
- Reset values:
  - o_wr_en=0, o_wr_addr=0, o_multicast=0.
  - o_used_cnt=0, o_drop_cnt=0, o_err_underflow=0.
  - Prefetch buffer empty (pf_cnt=0); FSM in INIT.
- Reset mid-operation: prefetched pointers are discarded. clr_80M is always asserted together with the GSM unit's clr, so no pointer leaks across reset.
- Prefetch:
  - o_hmp_rd = i_hmp_valid & (pf_cnt<PF_DEPTH | pop). Combinational.
  - i_hmp_addr is written into the prefetch buffer in the same cycle as o_hmp_rd.
  - A pointer pushed in cycle t is poppable from t+1; there is no bypass.
  - Simultaneous push and pop leaves pf_cnt unchanged.
- FSM states:
  - INIT: o_cell_ready=0. Goes to RUN when pf_cnt>=1 and !i_pause, or to PAUSE when i_pause.
  - RUN: cells accepted. Goes to PAUSE when i_pause.
  - PAUSE: o_cell_ready=0, prefetch continues. Goes to RUN when !i_pause.
  - i_pause takes effect on the next cycle; a cell accepted in the cycle i_pause rises still completes.
- Ready rule: o_cell_ready = (state==RUN) & (pf_cnt!=0 | i_cell_mcast==0).
- Accept with mcast!=0:
  - Pop the prefetch head.
  - Next cycle: o_wr_en=1, o_wr_addr=head, o_multicast=i_cell_mcast (registered, latency 1).
  - o_used_cnt increments.
- Accept with mcast==0:
  - No pop. o_wr_en stays 0.
  - o_drop_cnt increments, saturating at all-ones.
- o_wr_en is 0 in every cycle without an allocating accept. Throughput is one cell per cycle while pointers are available.
- o_used_cnt:
  - +1 on an allocating accept; -1 on i_bf_free_flag; unchanged when both occur in the same cycle.
  - A free pulse with count 0 and no allocate: count stays 0 and o_err_underflow is set; it is cleared only by reset.
  - The count never exceeds 2^AWIDTH, because the HMP is empty at that point.
- Prefetch empty while a nonzero-mcast cell waits: ready is low and the cell is held upstream. The stall is not counted as a drop.

Decomposition:
- Shared header gsm_defs.h holds:
  - FSM state encodings (INIT=2'd0, RUN=2'd1, PAUSE=2'd2).
  - The DCNT_WIDTH default.
  - The PF_DEPTH default.
- Sub-module gsm_ptr_prefetch:
  - Synchronous FIFO of PF_DEPTH entries, AWIDTH bits wide.
  - Ports: push, pop, data in/out, count, empty, full.
  - Pointer wrap-around when PF_DEPTH is not a power of two.
- Top level holds the FSM, the output registers and the counters.

Test Plan:
- Reset, then i_hmp_valid=1 with addrs 5,6,7 on consecutive cycles -> o_hmp_rd high for 2 cycles, pf_cnt=2, INIT->RUN one cycle after the first push, o_cell_ready=1.
- Cell mcast=4'b1010 accepted in RUN at cycle t -> at t+1 o_wr_en=1, o_wr_addr=5, o_multicast=4'b1010, o_used_cnt=1; the next cell gets addr 6.
- Back-to-back cells with HMP empty after 2 pointers -> third cell sees ready=0; when HMP supplies addr 9 at cycle t, the cell is accepted at t+1 and o_wr_addr=9 at t+2.
- Cell with mcast=0 while pf empty -> accepted, o_wr_en=0, o_drop_cnt 0->1; after 70000 drops o_drop_cnt=16'hFFFF.
- i_bf_free_flag coincident with an allocate at o_used_cnt=3 -> stays 3; free pulse at o_used_cnt=0 -> stays 0, o_err_underflow=1 until clr_80M.
- i_pause raised mid-stream -> one further accept possible in that cycle, then ready=0; prefetch refills to 2; on release, RUN and accepts resume next cycle; clr_80M asserted mid-burst -> all outputs return to reset values next cycle.
